// File: rtl/countdown_timer.sv
// countdown_timer: 1 Hz count-down timer with done pulse and latched alarm; define AUTO_RELOAD_EN for periodic reload mode
module countdown_timer #(
    parameter int CLK_DIV = 10,
    parameter int WIDTH   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic             start_stop,
    input  logic             clear_btn,
    output logic [WIDTH-1:0] seconds,
    output logic             running,
    output logic             done,
    output logic             alarm
);
    localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;

    typedef enum logic [1:0] {IDLE, RUN, PAUSE, EXPIRED} state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] seconds_q, seconds_d;
    logic [WIDTH-1:0] reload_q, reload_d;
    logic [PW-1:0]    presc_q, presc_d;
    logic             running_q, running_d;
    logic             done_q, done_d;
    logic             alarm_q, alarm_d;
    logic             tick;

    assign tick = (state_q == RUN) && (presc_q == PW'(CLK_DIV - 1));

    // next-state, counter and output logic; clear beats load beats start_stop
    always_comb begin
        state_d   = state_q;
        seconds_d = seconds_q;
        reload_d  = reload_q;
        alarm_d   = alarm_q;
        done_d    = 1'b0;
        if (clear_btn) begin
            seconds_d = '0;
            alarm_d   = 1'b0;
            state_d   = IDLE;
        end else if (load && state_q != RUN) begin
            seconds_d = load_value;
            reload_d  = load_value;
            alarm_d   = 1'b0;
            state_d   = IDLE;
        end else begin
            unique case (state_q)
                IDLE:    state_d = (start_stop && seconds_q != '0) ? RUN : IDLE;
                RUN: begin
                    if (tick && seconds_q <= WIDTH'(1)) begin
                        done_d = 1'b1;
`ifdef AUTO_RELOAD_EN
                        seconds_d = reload_q;
`else
                        seconds_d = '0;
                        alarm_d   = 1'b1;
                        state_d   = EXPIRED;
`endif
                    end else begin
                        seconds_d = tick ? seconds_q - WIDTH'(1) : seconds_q;
                        state_d   = start_stop ? PAUSE : RUN;
                    end
                end
                PAUSE:   state_d = start_stop ? RUN : PAUSE;
                EXPIRED: begin
                    alarm_d = start_stop ? 1'b0 : alarm_q;
                    state_d = start_stop ? IDLE : EXPIRED;
                end
                default: state_d = IDLE;
            endcase
        end
        presc_d   = (state_q == RUN && state_d == RUN && !tick) ? presc_q + PW'(1) : '0;
        running_d = (state_d == RUN);
    end

    // state and datapath registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            seconds_q <= '0;
            reload_q  <= '0;
            presc_q   <= '0;
            running_q <= 1'b0;
            done_q    <= 1'b0;
            alarm_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            seconds_q <= seconds_d;
            reload_q  <= reload_d;
            presc_q   <= presc_d;
            running_q <= running_d;
            done_q    <= done_d;
            alarm_q   <= alarm_d;
        end
    end

    assign seconds = seconds_q;
    assign running = running_q;
    assign done    = done_q;
    assign alarm   = alarm_q;
endmodule

// File: tb/tb_countdown_timer.sv
// tb_countdown_timer: directed self-checking bench for countdown_timer (CLK_DIV=10, WIDTH=8)
module tb_countdown_timer;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       load = 1'b0;
    logic [7:0] load_value = '0;
    logic       start_stop = 1'b0;
    logic       clear_btn = 1'b0;
    logic [7:0] seconds;
    logic       running, done, alarm;
    int         n_assert = 0;
    int         n_fail = 0;

    countdown_timer #(.CLK_DIV(10), .WIDTH(8)) dut (
        .clk(clk), .rst(rst), .load(load), .load_value(load_value),
        .start_stop(start_stop), .clear_btn(clear_btn),
        .seconds(seconds), .running(running), .done(done), .alarm(alarm)
    );

    always #5 clk = ~clk;

    task automatic step(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input int obs, input int exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic do_load(input logic [7:0] v);
        load_value = v;
        load = 1'b1;
        step();
        load = 1'b0;
    endtask

    task automatic press(input int n = 1);
        start_stop = 1'b1;
        step();
        start_stop = 1'b0;
    endtask

    task automatic do_clear();
        clear_btn = 1'b1;
        step();
        clear_btn = 1'b0;
    endtask

    initial begin
        step(2);
        chk("rst_seconds", seconds, 0);
        chk("rst_running", running, 0);
        chk("rst_done", done, 0);
        chk("rst_alarm", alarm, 0);
        rst = 1'b0;
        step();
        press();
        chk("zero_running", running, 0);
        chk("zero_seconds", seconds, 0);
        chk("zero_done", done, 0);
        step(3);
        chk("zero_running_later", running, 0);
`ifndef AUTO_RELOAD_EN
        do_load(8'd5);
        chk("t1_loaded", seconds, 5);
        press();
        chk("t1_running", running, 1);
        step(9);
        chk("t1_before_tick", seconds, 5);
        step();
        chk("t1_sec4", seconds, 4);
        step(10);
        chk("t1_sec3", seconds, 3);
        step(10);
        chk("t1_sec2", seconds, 2);
        step(10);
        chk("t1_sec1", seconds, 1);
        step(9);
        chk("t1_pre_done", done, 0);
        step();
        chk("t1_sec0", seconds, 0);
        chk("t1_done", done, 1);
        chk("t1_alarm", alarm, 1);
        chk("t1_running0", running, 0);
        step();
        chk("t1_done_pulse", done, 0);
        chk("t1_alarm_held", alarm, 1);
        press();
        chk("t1_ack_alarm", alarm, 0);
        chk("t1_ack_running", running, 0);
        do_load(8'd3);
        press();
        step(9);
        press();
        chk("tie_dec", seconds, 2);
        chk("tie_paused", running, 0);
        do_clear();
        do_load(8'd1);
        press();
        step(9);
        press();
        chk("win_seconds", seconds, 0);
        chk("win_done", done, 1);
        chk("win_alarm", alarm, 1);
        chk("win_running", running, 0);
        do_load(8'd4);
        chk("exp_load_sec", seconds, 4);
        chk("exp_load_alarm", alarm, 0);
        do_clear();
`else
        do_load(8'd2);
        press();
        step(10);
        chk("ar_sec1", seconds, 1);
        step(10);
        chk("ar_reload", seconds, 2);
        chk("ar_done", done, 1);
        chk("ar_alarm", alarm, 0);
        chk("ar_running", running, 1);
        step();
        chk("ar_done_pulse", done, 0);
        step(9);
        chk("ar_sec1b", seconds, 1);
        step(10);
        chk("ar_done2", done, 1);
        chk("ar_reload2", seconds, 2);
        chk("ar_running2", running, 1);
        do_clear();
`endif
        do_load(8'd3);
        press();
        step(15);
        chk("t2_sec2", seconds, 2);
        press();
        chk("t2_paused", running, 0);
        step(100);
        chk("t2_held", seconds, 2);
        press();
        chk("t2_resumed", running, 1);
        step(9);
        chk("t2_pre", seconds, 2);
        step();
        chk("t2_sec1", seconds, 1);
        do_load(8'd9);
        chk("t4_load_ignored", seconds, 1);
        chk("t4_still_run", running, 1);
        clear_btn = 1'b1;
        load = 1'b1;
        load_value = 8'd7;
        start_stop = 1'b1;
        step();
        clear_btn = 1'b0;
        load = 1'b0;
        start_stop = 1'b0;
        chk("t4_all_sec", seconds, 0);
        chk("t4_all_run", running, 0);
        chk("t4_all_alarm", alarm, 0);
        do_load(8'd200);
        press();
        step(36);
        chk("t5_pre_rst", seconds, 197);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_sec", seconds, 0);
        chk("t5_run", running, 0);
        chk("t5_done", done, 0);
        chk("t5_alarm", alarm, 0);
        step(12);
        chk("t5_sec_later", seconds, 0);
        chk("t5_run_later", running, 0);
        do_load(8'd3);
        step(12);
        chk("t5_idle_no_dec", seconds, 3);
        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
